// File: rtl/alu_exec_unit_pkg.sv
// Shared constants for the ALU execution unit.
// Holds the data/register-id widths, the ALU op codes and the sequencer
// state encoding used by alu_exec_unit and alu64.
package alu_exec_unit_pkg;

   localparam int unsigned DataW  = 64;
   localparam int unsigned RegIdW = 4;

   typedef enum logic [1:0] {
      OpAdd = 2'd0,
      OpSub = 2'd1,
      OpMul = 2'd2,
      OpDiv = 2'd3
   } alu_op_e;

   // Sequencer states
   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StRd1  = 3'd1;
   localparam logic [2:0] StRd2  = 3'd2;
   localparam logic [2:0] StCalc = 3'd3;
   localparam logic [2:0] StWr   = 3'd4;
   localparam logic [2:0] StDone = 3'd5;

   localparam logic [DataW-1:0] DataMin  = {1'b1, {(DataW-1){1'b0}}};
   localparam logic [DataW-1:0] DataOnes = {DataW{1'b1}};

endpackage

// File: rtl/alu64.sv
// Combinational 64-bit ALU with sign/zero flags.
// Ports:
//   i_op          op code (ADD, SUB, MUL, DIV)
//   i_a, i_b      operands
//   o_c           result, wraps modulo 2^64
//   o_neg/o_pos/o_zero  result flags
module alu64
   import alu_exec_unit_pkg::*;
(
   input  logic [1:0]       i_op,
   input  logic [DataW-1:0] i_a,
   input  logic [DataW-1:0] i_b,
   output logic [DataW-1:0] o_c,
   output logic             o_neg,
   output logic             o_pos,
   output logic             o_zero
);

   logic [DataW-1:0] w_c;

   always_comb begin
      w_c = '0;
      unique case (i_op)
         OpAdd: w_c = i_a + i_b;
         OpSub: w_c = i_a - i_b;
         OpMul: w_c = i_a * i_b;
         OpDiv: begin
            // Divide-by-zero and the single overflowing quotient are pinned
            // explicitly so the result never depends on simulator behaviour.
            if (i_b == '0) begin
               w_c = DataOnes;
            end else if (i_a == DataMin && i_b == DataOnes) begin
               w_c = DataMin;
            end else begin
               w_c = $signed(i_a) / $signed(i_b);
            end
         end
         default: w_c = '0;
      endcase
   end

   assign o_c    = w_c;
   assign o_neg  = w_c[DataW-1];
   assign o_zero = (w_c == '0);
   assign o_pos  = !o_neg && !o_zero;

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: combinational ALU, instruction-pointer counter and a
// register-to-register sequencer (read r1, read r2, compute, write r0).
// Ports:
//   clk, rst                 clock, async active-high reset
//   op, alu_a, alu_b         ALU op and external operands (used in IDLE)
//   alu_c, alu_neg/pos/zero  ALU result and flags
//   ip_inc, ip_set, ip_data  IP control; ip_val is the current IP
//   enabled, r0, r1, r2      start/hold an op; dest, src A, src B ids
//   reg_id, reg_re, reg_we, reg_wd, reg_out  register-file interface
//   finished                 op complete
module alu_exec_unit
   import alu_exec_unit_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        op,
   input  logic [DataW-1:0]  alu_a,
   input  logic [DataW-1:0]  alu_b,
   output logic [DataW-1:0]  alu_c,
   output logic              alu_neg,
   output logic              alu_pos,
   output logic              alu_zero,
   input  logic              ip_inc,
   input  logic              ip_set,
   input  logic [DataW-1:0]  ip_data,
   output logic [DataW-1:0]  ip_val,
   input  logic              enabled,
   input  logic [RegIdW-1:0] r0,
   input  logic [RegIdW-1:0] r1,
   input  logic [RegIdW-1:0] r2,
   output logic [RegIdW-1:0] reg_id,
   output logic              reg_re,
   output logic              reg_we,
   output logic [DataW-1:0]  reg_wd,
   input  logic [DataW-1:0]  reg_out,
   output logic              finished
);

   logic [2:0]       r_state;
   logic [2:0]       w_state_next;
   logic [DataW-1:0] r_a;
   logic [DataW-1:0] r_b;
   logic [DataW-1:0] r_ip;
   logic [DataW-1:0] w_alu_a;
   logic [DataW-1:0] w_alu_b;
   logic [DataW-1:0] w_alu_c;

   // Outside IDLE the ALU works on the latched register operands
   assign w_alu_a = (r_state == StIdle) ? alu_a : r_a;
   assign w_alu_b = (r_state == StIdle) ? alu_b : r_b;

   alu64 u_alu (
      .i_op   (op),
      .i_a    (w_alu_a),
      .i_b    (w_alu_b),
      .o_c    (w_alu_c),
      .o_neg  (alu_neg),
      .o_pos  (alu_pos),
      .o_zero (alu_zero)
   );

   assign alu_c  = w_alu_c;
   assign ip_val = r_ip;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ip <= '0;
      end else if (ip_set) begin
         r_ip <= ip_data;
      end else if (ip_inc) begin
         r_ip <= r_ip + 64'd1;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (r_state == StIdle) begin
         if (enabled) w_state_next = StRd1;
      end else if (!enabled) begin
         // Dropping enabled aborts from any active state
         w_state_next = StIdle;
      end else begin
         unique case (r_state)
            StRd1:   w_state_next = StRd2;
            StRd2:   w_state_next = StCalc;
            StCalc:  w_state_next = StWr;
            StWr:    w_state_next = StDone;
            StDone:  w_state_next = StDone;
            default: w_state_next = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;
         r_a     <= '0;
         r_b     <= '0;
      end else begin
         r_state <= w_state_next;
         // reg_out carries the data requested one cycle earlier
         if (r_state == StRd2)  r_a <= reg_out;
         if (r_state == StCalc) r_b <= reg_out;
      end
   end

   always_comb begin
      reg_id   = '0;
      reg_re   = 1'b0;
      reg_we   = 1'b0;
      reg_wd   = '0;
      finished = 1'b0;
      unique case (r_state)
         StRd1: begin
            reg_id = r1;
            reg_re = 1'b1;
         end
         StRd2: begin
            reg_id = r2;
            reg_re = 1'b1;
         end
         StWr: begin
            if (enabled) begin
               reg_id = r0;
               reg_we = 1'b1;
               reg_wd = w_alu_c;
            end
         end
         StDone:  finished = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed and random ALU checks,
// IP counter checks, and register-to-register ops checked by a write
// scoreboard against a behavioural register-file model.
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  op;
   logic [63:0] alu_a, alu_b, alu_c;
   logic        alu_neg, alu_pos, alu_zero;
   logic        ip_inc, ip_set;
   logic [63:0] ip_data, ip_val;
   logic        enabled;
   logic [3:0]  r0, r1, r2, reg_id;
   logic        reg_re, reg_we, finished;
   logic [63:0] reg_wd;
   logic [63:0] reg_out = 64'd0;

   int checks   = 0;
   int failures = 0;

   logic [67:0] exp_q[$];
   logic [63:0] init_vals[16];
   logic [63:0] exp_regs[16];
   logic [63:0] regs[16];
   logic        rf_loaded = 1'b0;

   always #5 clk = ~clk;

   alu_exec_unit dut (
      .clk      (clk),
      .rst      (rst),
      .op       (op),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_c    (alu_c),
      .alu_neg  (alu_neg),
      .alu_pos  (alu_pos),
      .alu_zero (alu_zero),
      .ip_inc   (ip_inc),
      .ip_set   (ip_set),
      .ip_data  (ip_data),
      .ip_val   (ip_val),
      .enabled  (enabled),
      .r0       (r0),
      .r1       (r1),
      .r2       (r2),
      .reg_id   (reg_id),
      .reg_re   (reg_re),
      .reg_we   (reg_we),
      .reg_wd   (reg_wd),
      .reg_out  (reg_out),
      .finished (finished)
   );

   // Register-file model: read data valid the cycle after reg_re
   always @(posedge clk) begin
      if (!rf_loaded) begin
         for (int i = 0; i < 16; i++) regs[i] <= init_vals[i];
         rf_loaded <= 1'b1;
      end else begin
         if (reg_re) reg_out <= regs[reg_id];
         if (reg_we) regs[reg_id] <= reg_wd;
      end
   end

   // Write monitor: every reg_we must match the oldest expected write
   always @(negedge clk) begin
      if (reg_we) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write actual id=%0d data=%h required no write",
                     reg_id, reg_wd);
         end else begin
            logic [67:0] e;
            e = exp_q.pop_front();
            if ({reg_id, reg_wd} !== e) begin
               failures++;
               $display("FAIL reg_write actual id=%0d data=%h required id=%0d data=%h",
                        reg_id, reg_wd, e[67:64], e[63:0]);
            end
         end
      end
   end

   function automatic logic [63:0] ref_alu(input logic [1:0] o, input logic [63:0] a,
                                           input logic [63:0] b);
      logic [63:0] ma, mb, q;
      case (o)
         2'd0: return a + b;
         2'd1: return a - b;
         2'd2: return a * b;
         default: begin
            if (b == 64'd0) return {64{1'b1}};
            ma = a[63] ? (64'd0 - a) : a;
            mb = b[63] ? (64'd0 - b) : b;
            q  = ma / mb;
            return (a[63] ^ b[63]) ? (64'd0 - q) : q;
         end
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic alu_check(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
      logic [63:0] e;
      op = o; alu_a = a; alu_b = b;
      #1;
      e = ref_alu(o, a, b);
      check("alu_c", alu_c, e);
      check("alu_flags", {61'd0, alu_neg, alu_pos, alu_zero},
            {61'd0, e[63], !e[63] && e != 0, e == 0});
   endtask

   task automatic run_op(input logic [1:0] o, input logic [3:0] d, input logic [3:0] s1,
                         input logic [3:0] s2, input int hold);
      logic [63:0] e;
      @(posedge clk); #1;
      op = o; r0 = d; r1 = s1; r2 = s2; enabled = 1'b1;
      e = ref_alu(o, exp_regs[s1], exp_regs[s2]);
      exp_regs[d] = e;
      exp_q.push_back({d, e});
      @(posedge clk); #1;
      check("rd1_strobe", {59'd0, reg_re, reg_id}, {59'd1, s1});
      @(posedge clk); #1;
      check("rd2_strobe", {59'd0, reg_re, reg_id}, {59'd1, s2});
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("wr_strobe", {63'd0, reg_we}, 64'd1);
      check("wr_not_finished", {63'd0, finished}, 64'd0);
      @(posedge clk); #1;
      check("finished_edge4", {63'd0, finished}, 64'd1);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("finished_hold", {63'd0, finished}, 64'd1);
      end
      enabled = 1'b0;
      @(posedge clk); #1;
      check("idle_after_done", {62'd0, finished, reg_re}, 64'd0);
   endtask

   initial begin
      rst = 1'b1; op = 2'd0; alu_a = 0; alu_b = 0;
      ip_inc = 0; ip_set = 0; ip_data = 0;
      enabled = 0; r0 = 0; r1 = 0; r2 = 0;
      for (int i = 0; i < 16; i++) init_vals[i] = {$urandom, $urandom};
      init_vals[1] = 64'd10;
      init_vals[2] = 64'd20;
      init_vals[4] = 64'h8000_0000_0000_0000;
      init_vals[6] = {64{1'b1}};
      init_vals[7] = 64'd0;
      for (int i = 0; i < 16; i++) exp_regs[i] = init_vals[i];

      #1;
      check("reset_outputs", {56'd0, reg_id, reg_re, reg_we, finished, 1'b0},
            64'd0);
      check("reset_wd", reg_wd, 64'd0);
      check("reset_ip", ip_val, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // ALU direct in IDLE
      alu_check(2'd0, 64'd5, 64'd7);
      check("add_5_7", alu_c, 64'd12);
      alu_check(2'd1, 64'd3, 64'd3);
      check("sub_zero_flag", {63'd0, alu_zero}, 64'd1);
      alu_check(2'd1, 64'd2, 64'd5);
      check("sub_neg", alu_c, 64'hFFFF_FFFF_FFFF_FFFD);
      alu_check(2'd2, 64'h1_0000_0000, 64'h1_0000_0000);
      check("mul_wrap", alu_c, 64'd0);
      alu_check(2'd3, -64'sd7, 64'd2);
      check("div_trunc", alu_c, -64'sd3);
      alu_check(2'd3, 64'd9, 64'd0);
      check("div_by_zero", alu_c, {64{1'b1}});
      alu_check(2'd3, 64'h8000_0000_0000_0000, {64{1'b1}});
      check("div_overflow", alu_c, 64'h8000_0000_0000_0000);
      for (int i = 0; i < 24; i++) begin
         logic [63:0] a, b;
         a = {$urandom, $urandom};
         b = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 5)) : {$urandom, $urandom};
         alu_check(2'($urandom_range(0, 3)), a, b);
      end

      // IP counter
      ip_inc = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("ip_inc3", ip_val, 64'd3);
      ip_set = 1'b1; ip_data = 64'h100;
      @(posedge clk); #1;
      check("ip_set_priority", ip_val, 64'h100);
      ip_inc = 1'b0; ip_data = {64{1'b1}};
      @(posedge clk); #1;
      ip_set = 1'b0; ip_inc = 1'b1;
      @(posedge clk); #1;
      check("ip_wrap", ip_val, 64'd0);
      ip_inc = 1'b0;
      @(posedge clk); #1;
      check("ip_hold", ip_val, 64'd0);

      // Directed register ops
      run_op(2'd0, 4'd3, 4'd1, 4'd2, 2);
      check("add_r3_model", exp_regs[3], 64'd30);
      run_op(2'd0, 4'd5, 4'd5, 4'd5, 0);
      run_op(2'd3, 4'd8, 4'd4, 4'd6, 1);
      run_op(2'd3, 4'd9, 4'd1, 4'd7, 0);

      // Abort in CALC: no write
      @(posedge clk); #1;
      op = 2'd0; r0 = 4'd10; r1 = 4'd1; r2 = 4'd2; enabled = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      enabled = 1'b0;
      @(posedge clk); #1;
      check("abort_idle", {62'd0, finished, reg_re}, 64'd0);
      repeat (4) @(posedge clk);
      #1;
      check("abort_no_write", 64'(exp_q.size()), 64'd0);

      // Reset during RD2: outputs drop immediately, no write
      ip_set = 1'b1; ip_data = 64'h55;
      @(posedge clk); #1;
      ip_set = 1'b0;
      op = 2'd0; r0 = 4'd11; r1 = 4'd1; r2 = 4'd2; enabled = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rd2_before_rst", {59'd0, reg_re, reg_id}, {59'd1, 4'd2});
      rst = 1'b1;
      #1;
      check("rst_async_strobes", {56'd0, reg_id, reg_re, reg_we, finished, 1'b0}, 64'd0);
      check("rst_async_ip", ip_val, 64'd0);
      enabled = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Random register ops
      for (int i = 0; i < 30; i++) begin
         run_op(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                $urandom_range(0, 2));
      end

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      for (int i = 0; i < 16; i++) check("regfile_final", regs[i], exp_regs[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the clock port is clk and the reset port is rst.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock, rising edge
- rst  in  1  async active-high reset
- op  in  2  ALU op: 0 ADD, 1 SUB, 2 MUL, 3 DIV
- alu_a, alu_b  in  64  external ALU operands
- alu_c  out  64  ALU result
- alu_neg, alu_pos, alu_zero  out  1  result flags
- ip_inc  in  1  increment IP
- ip_set  in  1  load IP
- ip_data  in  64  IP load value
- ip_val  out  64  current instruction pointer
- enabled  in  1  start/hold a register-to-register op
- r0, r1, r2  in  4  destination, source A, source B register ids
- reg_id  out  4  register-file address
- reg_re  out  1  register-file read strobe
- reg_we  out  1  register-file write strobe
- reg_wd  out  64  register-file write data
- reg_out  in  64  register-file read data, valid the cycle after reg_re
- finished  out  1  operation complete
REQ-003 The block SHALL have no parameters; the data width is fixed at 64 and the register id width at 4.

Function
REQ-004 The ALU SHALL be combinational: ADD a+b, SUB a-b, MUL low 64 bits of a*b, DIV signed quotient truncated toward zero; all results wrap modulo 2^64.
REQ-005 DIV by zero SHALL return 0xFFFF_FFFF_FFFF_FFFF; DIV of 0x8000_0000_0000_0000 by -1 SHALL return 0x8000_0000_0000_0000.
REQ-006 Flags SHALL be: alu_neg = c[63]; alu_zero = (c == 0); alu_pos = !alu_neg && !alu_zero.
REQ-007 In IDLE the ALU SHALL take operands from op, alu_a and alu_b; in every other state it SHALL take them from op and the latched operands a_q and b_q.
REQ-008 On each clock edge ip_val SHALL load ip_data when ip_set=1, else increment by 1 (wrapping) when ip_inc=1, else hold; ip_set has priority over ip_inc.
REQ-009 The sequencer SHALL have the states IDLE, RD1, RD2, CALC, WR and DONE.
REQ-010 IDLE: all strobes 0; if enabled=1, go to RD1.
REQ-011 RD1: reg_id=r1, reg_re=1; go to RD2.
REQ-012 RD2: reg_id=r2, reg_re=1; latch a_q<=reg_out; go to CALC.
REQ-013 CALC: latch b_q<=reg_out; go to WR.
REQ-014 WR: reg_id=r0, reg_we=1, reg_wd=ALU(op, a_q, b_q); go to DONE.
REQ-015 DONE: finished=1; stay while enabled=1; go to IDLE when enabled=0.
REQ-016 reg_id, reg_re, reg_we, reg_wd and finished SHALL be combinational decodes of the state; reg_wd and reg_id SHALL be 0 whenever their strobe is 0.
REQ-017 If enabled=0 in any state other than IDLE, the next state SHALL be IDLE, and reg_we SHALL be gated off by enabled=0 in WR, so an aborted op never writes.
REQ-018 Latency: with enabled sampled high at edge 0, the write occurs at edge 4 and finished is high from edge 4 onward.
REQ-019 r1 == r2 and r0 == r1 SHALL be legal: sources are read before the write.
REQ-020 op, r0, r1 and r2 SHALL be held stable by the user while enabled=1.

Reset
REQ-021 On rst=1 the block SHALL asynchronously clear: state=IDLE, a_q=0, b_q=0, ip_val=0.
REQ-022 Consequently all strobes, reg_id, reg_wd and finished SHALL be 0 during reset.
REQ-023 A reset mid-operation SHALL abort it with no write.
REQ-024 After reset release the block SHALL accept a new op on the next edge at which enabled=1.

Structure
REQ-025 A shared package SHALL hold the ALU op codes (ADD=0, SUB=1, MUL=2, DIV=3), the sequencer state encoding and the width constants 64 and 4.
REQ-026 The ALU SHALL be one sub-module, alu64, instantiated once.
REQ-027 The IP counter and the sequencer SHALL live in the top module.

Verification
REQ-028 ALU direct, IDLE:
- ADD 5+7 -> c=12, pos=1
- SUB 3-3 -> c=0, zero=1
- SUB 2-5 -> c=0xFFFF_FFFF_FFFF_FFFD, neg=1
REQ-029 MUL 0x1_0000_0000 * 0x1_0000_0000 -> c=0; DIV -7/2 -> -3; DIV 9/0 -> all ones.
REQ-030 IP counter:
- reset -> ip_val=0
- inc 3 cycles -> 3
- set 0x100 together with inc -> 0x100
- set 0xFFFF_FFFF_FFFF_FFFF then inc -> 0
REQ-031 ADD r3=r1+r2 with a bench regfile model (r1=10, r2=20) -> reg_re on r1 then r2, reg_we on r3 with reg_wd=30 at edge 4, finished high until enabled drops, then IDLE.
REQ-032 Abort: enabled drops in CALC -> no reg_we pulse, state IDLE; rst asserted during RD2 -> outputs 0 immediately, no write.
